// File: rtl/upscaler_audio_pkg.sv
// Shared constants for the audio upscaler path: sample widths and the
// phase step that yields 48 kHz from a 74.25 MHz pixel clock.
package upscaler_audio_pkg;

  localparam int AUDIO_DATA_WIDTH = 12;
  localparam int AUDIO_OUT_WIDTH  = 16;
  localparam int PHASE_INC_48K    = 10846;

  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through sample buffer. A push into a full FIFO is only
// accepted when a pop happens in the same cycle.
module sample_fifo
  import upscaler_audio_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == FULL_LEVEL);
  assign level   = level_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Gating the head keeps stale contents invisible after a reset.
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/sample_rate_decimator.sv
// Phase-accumulator decimator: captures one filtered sample per accumulator
// carry, widens it and queues it for the output consumer, counting drops.
module sample_rate_decimator
  import upscaler_audio_pkg::*;
#(
  parameter int DATA_WIDTH  = AUDIO_DATA_WIDTH,
  parameter int OUT_WIDTH   = AUDIO_OUT_WIDTH,
  parameter int PHASE_WIDTH = 24,
  parameter int PHASE_INC   = PHASE_INC_48K,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [DATA_WIDTH-1:0]  data_in,
  output logic signed [OUT_WIDTH-1:0]   out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          overflow,
  input  logic                          clear_ovf,
  output logic [7:0]                    drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

  localparam logic [PHASE_WIDTH:0] INC_EXT = (PHASE_WIDTH + 1)'(PHASE_INC);

  logic [PHASE_WIDTH-1:0]      acc_q, acc_d;
  logic [PHASE_WIDTH:0]        acc_sum;
  logic                        tick;
  logic signed [OUT_WIDTH-1:0] sample_ext, sample_conv;
  logic                        fifo_full, fifo_empty;
  logic                        pop, push, drop;
  logic                        ovf_q, ovf_d;
  logic [7:0]                  drop_cnt_q, drop_cnt_d;

  assign acc_sum = {1'b0, acc_q} + INC_EXT;
  assign tick    = acc_sum[PHASE_WIDTH];
  assign acc_d   = acc_sum[PHASE_WIDTH-1:0];

  assign sample_ext  = OUT_WIDTH'(data_in);
  assign sample_conv = sample_ext <<< (OUT_WIDTH - DATA_WIDTH);

  // A full FIFO can still take the tick sample if the consumer frees a slot.
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign push      = tick && (!fifo_full || pop);
  assign drop      = tick && fifo_full && !pop;

  always_comb begin
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (clear_ovf) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign overflow   = ovf_q;
  assign drop_count = drop_cnt_q;

  sample_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (sample_conv),
    .dout  (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fill_level)
  );

endmodule

// File: tb/tb_sample_rate_decimator.sv
// Bench for sample_rate_decimator with a 16-bit accumulator stepping 4096,
// giving one tick every 16 clocks and an 8-deep output buffer.
module tb_sample_rate_decimator;

  localparam int DW    = 12;
  localparam int OW    = 16;
  localparam int PW    = 16;
  localparam int INC   = 4096;
  localparam int DEPTH = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic signed [DW-1:0] data_in = '0;
  logic signed [OW-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic                 overflow;
  logic                 clear_ovf = 1'b0;
  logic [7:0]           drop_count;
  logic [3:0]           fill_level;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit ramp = 0;

  always #5 clk = ~clk;

  sample_rate_decimator #(
    .DATA_WIDTH  (DW),
    .OUT_WIDTH   (OW),
    .PHASE_WIDTH (PW),
    .PHASE_INC   (INC),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overflow   (overflow),
    .clear_ovf  (clear_ovf),
    .drop_count (drop_count),
    .fill_level (fill_level)
  );

  task automatic check_output(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Reference: phase as plain modular arithmetic, buffer as a queue,
  // conversion as multiplication by 2^(OW-DW).
  int m_phase = 0;
  int m_q[$];
  bit m_ovf = 0;
  int m_drops = 0;
  bit m_pop, m_tick, m_drop;
  int m_sum;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = 0;
      m_q.delete();
      m_ovf   = 0;
      m_drops = 0;
    end else begin
      m_pop   = (m_q.size() > 0) && out_ready;
      m_sum   = m_phase + INC;
      m_tick  = (m_sum >= (1 << PW));
      m_phase = m_sum % (1 << PW);
      m_drop  = m_tick && (m_q.size() == DEPTH) && !m_pop;
      if (m_pop) void'(m_q.pop_front());
      if (m_tick && !m_drop) m_q.push_back(int'(data_in) * (1 << (OW - DW)));
      if (clear_ovf) begin
        m_ovf   = 0;
        m_drops = 0;
      end else if (m_drop) begin
        m_ovf   = 1;
        m_drops = (m_drops < 255) ? m_drops + 1 : 255;
      end
    end
  end

  always @(negedge clk) begin
    check_output("out_valid", int'(out_valid), int'(m_q.size() != 0));
    check_output("fill_level", int'(fill_level), m_q.size());
    check_output("overflow", int'(overflow), int'(m_ovf));
    check_output("drop_count", int'(drop_count), m_drops);
    if (m_q.size() != 0)
      check_output("out_data", int'(out_data), m_q[0]);
    else if (!rst)
      check_output("out_data_reset", int'(out_data), 0);
  end

  task automatic apply_stimulus();
    cyc++;
    if (ramp) data_in = DW'(cyc);
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    cyc = 0;
  endtask

  task automatic wait_valid(input int budget, output int n, output bit ok);
    n  = 0;
    ok = 0;
    while (n < budget && !ok) begin
      apply_stimulus();
      n++;
      if (out_valid) ok = 1;
    end
  endtask

  int n;
  bit ok;

  initial begin
    // Tick spacing and width conversion with a free-running consumer
    out_ready = 1'b1;
    data_in   = 12'sd1000;
    do_reset();
    wait_valid(40, n, ok);
    check_output("first_tick_seen", int'(ok), 1);
    check_output("first_tick_cycle", n, 16);
    check_output("conv_pos", int'(out_data), 16000);
    data_in = -12'sd2048;
    apply_stimulus();
    check_output("valid_one_cycle", int'(out_valid), 0);
    wait_valid(40, n, ok);
    check_output("second_tick_seen", int'(ok), 1);
    check_output("tick_period", n + 1, 16);
    check_output("conv_neg", int'(out_data), -32768);

    // Stalled consumer: fill, overflow, then a pop exactly on a tick
    out_ready = 1'b0;
    ramp      = 1;
    do_reset();
    repeat (128) apply_stimulus();
    check_output("fill_after_8_ticks", int'(fill_level), 8);
    check_output("ovf_before_drop", int'(overflow), 0);
    repeat (72) apply_stimulus();
    check_output("fill_at_200", int'(fill_level), 8);
    check_output("ovf_at_200", int'(overflow), 1);
    check_output("drops_at_200", int'(drop_count), 4);
    repeat (7) apply_stimulus();
    out_ready = 1'b1;
    apply_stimulus();
    out_ready = 1'b0;
    check_output("fill_pop_on_tick", int'(fill_level), 8);
    check_output("drops_pop_on_tick", int'(drop_count), 4);
    apply_stimulus();
    check_output("fill_after_pulse", int'(fill_level), 8);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_output("drain_order", int'(out_data), (i < 7) ? 256 * (i + 2) : 3328);
      apply_stimulus();
    end

    // Clear landing on the same edge as a drop
    out_ready = 1'b0;
    do_reset();
    repeat (159) apply_stimulus();
    check_output("drops_before_clear", int'(drop_count), 1);
    clear_ovf = 1'b1;
    apply_stimulus();
    clear_ovf = 1'b0;
    check_output("ovf_after_clear", int'(overflow), 0);
    check_output("drops_after_clear", int'(drop_count), 0);
    repeat (16) apply_stimulus();
    check_output("drops_after_next", int'(drop_count), 1);

    // Reset while the buffer holds five samples
    do_reset();
    repeat (85) apply_stimulus();
    check_output("fill_before_reset", int'(fill_level), 5);
    rst = 1'b0;
    #1;
    check_output("valid_in_reset", int'(out_valid), 0);
    check_output("fill_in_reset", int'(fill_level), 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    cyc = 0;
    wait_valid(40, n, ok);
    check_output("post_reset_tick_seen", int'(ok), 1);
    check_output("post_reset_tick_cycle", n, 16);
    check_output("post_reset_sample", int'(out_data), 256);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
